rams_sp_nc: RTL and testbench



---
 rtl/rams_sp_nc_pkg.sv | 8 +
 rtl/rams_sp_nc_parity.sv | 11 +
 rtl/rams_sp_nc.sv | 83 ++++++++
 tb/tb_rams_sp_nc.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rams_sp_nc_pkg.sv
// Shared sizing defaults for the rams_sp_nc single-port no-change RAM.
package rams_sp_nc_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 10;
  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int DEPTH_DEFAULT      = 2 ** ADDR_WIDTH_DEFAULT;

endpackage

// File: rtl/rams_sp_nc_parity.sv
// Combinational even-parity generator: XOR reduction of a data word.
module rams_sp_nc_parity #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/rams_sp_nc.sv
// Single-port synchronous RAM with no-change write mode and registered output.
// Optional per-word parity storage and checking under RAMS_SP_NC_PARITY_EN.
module rams_sp_nc
  import rams_sp_nc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] dout
`ifdef RAMS_SP_NC_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Contents survive reset; only the output register is cleared.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic wr_en;
  logic rd_en;

  assign wr_en = en & we & ~rst;
  assign rd_en = en & ~we;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= di;
    end
  end

  // Writes leave dout untouched, so only read edges load the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_en) begin
      dout <= mem[addr];
    end
  end

`ifdef RAMS_SP_NC_PARITY_EN
  logic par_mem [DEPTH] = '{default: 1'b0};
  logic wr_par;
  logic rd_par;
  logic par_q;

  rams_sp_nc_parity #(.WIDTH(DATA_WIDTH)) u_wr_parity (
    .data   (di),
    .parity (wr_par)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[addr] <= wr_par;
    end
  end

  // Stored parity is registered with dout; checking the registered word keeps
  // the array read synchronous and makes the flag hold exactly when dout holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (rd_en) begin
      par_q <= par_mem[addr];
    end
  end

  rams_sp_nc_parity #(.WIDTH(DATA_WIDTH)) u_rd_parity (
    .data   (dout),
    .parity (rd_par)
  );

  assign parity_err = (rd_par != par_q);
`endif

endmodule

// File: tb/tb_rams_sp_nc.sv
// Scoreboard bench for rams_sp_nc: directed vectors push expected dout, a
// negedge monitor pops and compares; parity vectors run with RAMS_SP_NC_PARITY_EN.
module tb_rams_sp_nc;
  import rams_sp_nc_pkg::*;

  localparam int AW = ADDR_WIDTH_DEFAULT;
  localparam int DW = DATA_WIDTH_DEFAULT;
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH_DEFAULT - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic [DW-1:0] dout;
`ifdef RAMS_SP_NC_PARITY_EN
  logic          parity_err;
`endif

  rams_sp_nc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .we   (we),
    .addr (addr),
    .di   (di),
    .dout (dout)
`ifdef RAMS_SP_NC_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
    logic [DW-1:0] want;
    logic          want_perr;
    logic          corrupt;
  } vec_t;

  typedef struct {
    string         name;
    logic [DW-1:0] want;
    logic          want_perr;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void cmp(string name, logic [DW-1:0] act, logic [DW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endfunction

  task automatic v(string name, logic r, logic e, logic w, logic [AW-1:0] a,
                   logic [DW-1:0] d, logic [DW-1:0] want, logic perr, logic corrupt);
    vec_t t;
    t.name = name; t.rst = r; t.en = e; t.we = w; t.addr = a; t.di = d;
    t.want = want; t.want_perr = perr; t.corrupt = corrupt;
    vecs.push_back(t);
  endtask

  // Monitor: dout after edge N is checked at the following negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        automatic exp_t e = exp_q.pop_front();
        cmp(e.name, dout, e.want);
`ifdef RAMS_SP_NC_PARITY_EN
        cmp({e.name, "_perr"}, DW'(parity_err), DW'(e.want_perr));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; di = '0;

    //  name            rst  en   we   addr      di        dout      perr corrupt
    v("wr_005",         0,   1,   1,   10'h005,  16'h1234, 16'h0000, 0,   0);
    v("rd_005",         0,   1,   0,   10'h005,  16'h0000, 16'h1234, 0,   0);
    v("wr_1a0",         0,   1,   1,   10'h1A0,  16'hABCD, 16'h1234, 0,   0);
    v("rd_1a0",         0,   1,   0,   10'h1A0,  16'h0000, 16'hABCD, 0,   0);
    v("rd_005_again",   0,   1,   0,   10'h005,  16'h0000, 16'h1234, 0,   0);
    v("nochange_wr",    0,   1,   1,   10'h005,  16'hFFFF, 16'h1234, 0,   0);
    v("rd_005_new",     0,   1,   0,   10'h005,  16'h0000, 16'hFFFF, 0,   0);
    v("idle_we",        0,   0,   1,   ADDR_MAX, 16'h5555, 16'hFFFF, 0,   0);
    v("idle_rd",        0,   0,   0,   10'h1A0,  16'h0000, 16'hFFFF, 0,   0);
    v("rd_3ff_blank",   0,   1,   0,   ADDR_MAX, 16'h0000, 16'h0000, 0,   0);
    v("wr_000",         0,   1,   1,   10'h000,  16'h0F0F, 16'h0000, 0,   0);
    v("wr_3ff",         0,   1,   1,   ADDR_MAX, 16'hF00F, 16'h0000, 0,   0);
    v("rd_000",         0,   1,   0,   10'h000,  16'h0000, 16'h0F0F, 0,   0);
    v("rd_3ff",         0,   1,   0,   ADDR_MAX, 16'h0000, 16'hF00F, 0,   0);
    v("wr_1a0_b",       0,   1,   1,   10'h1A0,  16'h0001, 16'hF00F, 0,   0);
    v("rd_1a0_b",       0,   1,   0,   10'h1A0,  16'h0000, 16'h0001, 0,   0);
    v("rst_wr_blocked", 1,   1,   1,   10'h1A0,  16'h7777, 16'h0000, 0,   0);
    v("rst_rd_held",    1,   1,   0,   10'h005,  16'h0000, 16'h0000, 0,   0);
    v("post_rst_1a0",   0,   1,   0,   10'h1A0,  16'h0000, 16'h0001, 0,   0);
    v("post_rst_005",   0,   1,   0,   10'h005,  16'h0000, 16'hFFFF, 0,   0);
`ifdef RAMS_SP_NC_PARITY_EN
    v("par_wr_040",     0,   1,   1,   10'h040,  16'h1234, 16'hFFFF, 0,   1);
    v("par_rd_bad",     0,   1,   0,   10'h040,  16'h0000, 16'h1235, 1,   0);
    v("par_wr_hold",    0,   1,   1,   10'h041,  16'h0003, 16'h1235, 1,   0);
    v("par_rd_clean",   0,   1,   0,   10'h005,  16'h0000, 16'hFFFF, 0,   0);
`endif

    repeat (3) @(posedge clk);
    #1;
    cmp("reset_state", dout, 16'h0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      #2;
      if (vecs[i].rst && !rst) begin
        rst = 1'b1;
        #1;
        cmp("rst_async", dout, 16'h0000);
      end
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      we   = vecs[i].we;
      addr = vecs[i].addr;
      di   = vecs[i].di;
      @(posedge clk);
      #1;
      exp_q.push_back('{vecs[i].name, vecs[i].want, vecs[i].want_perr});
`ifdef RAMS_SP_NC_PARITY_EN
      if (vecs[i].corrupt) begin
        dut.mem[vecs[i].addr] = dut.mem[vecs[i].addr] ^ 16'h0001;
      end
`endif
    end

    @(negedge clk);
    #2;
    en = 1'b0;
    we = 1'b0;

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected results left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
